exec_unit: RTL and testbench
============================

EXEC_UNIT -- requirements
Module: exec_unit

Interface
REQ-001 The block SHALL have one parameter: DATA_BITS, default 8, giving the register, ALU and memory-word width.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL have no other ports; program and data live in an internal memory instance named "memory", holding an array "memory" of 256 x DATA_BITS words, addresses 0-255, that the bench loads hierarchically (dut.memory.memory[i]).

Function
REQ-005 The block SHALL contain the following state: 8-bit PC; 16 x DATA_BITS register file r0-r15; 1-bit zero flag Z; instruction register IR_HI and IR_LO; state machine.
REQ-006 Each instruction SHALL occupy two bytes: byte[PC] = {opcode[7:4], rd[3:0]} and byte[PC+1] = operand, where the operand is an immediate/address or {rs1[7:4], rs2[3:0]}.
REQ-007 Memory SHALL use combinational (asynchronous) read and synchronous write on the clk rising edge; memory contents SHALL NOT be reset.
REQ-008 The state machine SHALL cycle FETCH_HI -> FETCH_LO -> EXECUTE -> FETCH_HI, giving 3 cycles per instruction with no stalls.
REQ-009 FETCH_HI SHALL latch IR_HI = mem[PC] and set PC = PC+1; FETCH_LO SHALL latch IR_LO = mem[PC] and set PC = PC+1; PC arithmetic SHALL wrap modulo 256 (0xFF+1 = 0x00).
REQ-010 EXECUTE SHALL perform the decoded operation; opcodes, where imm = IR_LO and a = rs1, b = rs2 from IR_LO:
- 0x0 NOP: no effect.
- 0x1 MOVIR: rd = imm.
- 0x2 MOVRR: rd = r[rs1].
- 0x3 LOAD: rd = mem[imm].
- 0x4 STORE: mem[imm] = rd.
- 0x5 ADDRR: rd = ra + rb.
- 0x6 SUBRR: rd = ra - rb.
- 0x7 ANDRR, 0x8 ORRR, 0x9 XORRR: rd = ra op rb.
- 0xA ADDRI: rd = rd + imm.
- 0xB JMPI: PC = imm.
- 0xC JZI: PC = imm if Z = 1.
- 0xD JNZI: PC = imm if Z = 0.
- 0xE, 0xF: treated as NOP.
REQ-011 Arithmetic SHALL be DATA_BITS wide, modulo 2^DATA_BITS, with no carry or overflow flag.
REQ-012 Z SHALL be updated only by opcodes 0x5-0xA, set to (result == 0); all other opcodes SHALL leave Z unchanged.
REQ-013 When an ALU op has rd equal to a source register, it SHALL read the old values and write the result at the end of EXECUTE.
REQ-014 A STORE into the instruction stream (self-modifying code) SHALL take effect at the next fetch of that address.
REQ-015 Jump targets SHALL be any 8-bit value, odd addresses included; a jump in EXECUTE SHALL override the PC increment.
REQ-016 The jump field rd SHALL be ignored.

Reset
REQ-017 While reset = 1 the block SHALL asynchronously hold PC = 0, r0-r15 = 0, Z = 0, IR_HI = IR_LO = 0, state = FETCH_HI, and memory write enable inactive.
REQ-018 After reset deasserts, the first rising clk edge SHALL perform FETCH_HI at address 0.
REQ-019 Reset asserted mid-instruction SHALL abort that instruction with no register or memory write.

Verification
REQ-020 NOP-filled memory, reset pulse -> PC advances by 2 every 3 cycles, wraps 0xFE -> 0x00, and all registers stay 0.
REQ-021 Program 00 00, 10 01, 11 10, 41 10 -> after 12 cycles r0 = 1, r1 = 16, mem[16] = 16.
REQ-022 Continue with 51 10 (r1 = r1 + r0) and 41 07 -> r1 = 17, mem[7] = 17 (self-modifying), Z = 0; the next STORE at address 6 fetches its address operand from the new value.
REQ-023 MOVIR r2,0xFF; ADDRI r2,1 -> r2 = 0, Z = 1; JZI 0x20 is taken (PC = 0x20); JNZI 0x40 is not taken.
REQ-024 Reset asserted during the EXECUTE of a STORE -> memory unchanged, PC = 0, and the block restarts from address 0.

Source files
------------

// File: rtl/exec_unit.sv
// exec_unit: 8-bit-address accumulator-less register machine, 3-cycle fetch/fetch/execute loop
// with a 256-word unified program/data memory instance named "memory".
`default_nettype none

module exec_unit_mem #(
  parameter int DATA_BITS = 8
) (
  input  logic                 clk_i,
  input  logic                 we_i,
  input  logic [7:0]           addr_i,
  input  logic [DATA_BITS-1:0] wdata_i,
  output logic [DATA_BITS-1:0] rdata_o
);
  logic [DATA_BITS-1:0] memory [0:255];

  always_ff @(posedge clk_i) begin
    if (we_i) memory[addr_i] <= wdata_i;
  end

  assign rdata_o = memory[addr_i];
endmodule

module exec_unit #(
  parameter int DATA_BITS = 8
) (
  input logic clk,
  input logic reset
);
  typedef enum logic [1:0] {
    S_FETCH_HI = 2'd0,
    S_FETCH_LO = 2'd1,
    S_EXECUTE  = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [7:0]           pc_q, pc_d;
  logic [7:0]           ir_hi_q, ir_hi_d;
  logic [7:0]           ir_lo_q, ir_lo_d;
  logic                 z_q, z_d;
  logic [DATA_BITS-1:0] regs_q [16];

  logic                 rf_we;
  logic [DATA_BITS-1:0] rf_wdata;
  logic                 mem_we;
  logic [7:0]           mem_addr;
  logic [DATA_BITS-1:0] mem_rdata;
  logic [DATA_BITS-1:0] alu_res;

  logic [3:0]           opcode, rd, rs1, rs2;
  logic [DATA_BITS-1:0] op_a, op_b, op_d, imm_ext;

  assign opcode  = ir_hi_q[7:4];
  assign rd      = ir_hi_q[3:0];
  assign rs1     = ir_lo_q[7:4];
  assign rs2     = ir_lo_q[3:0];
  assign op_a    = regs_q[rs1];
  assign op_b    = regs_q[rs2];
  assign op_d    = regs_q[rd];
  assign imm_ext = DATA_BITS'(ir_lo_q);

  exec_unit_mem #(.DATA_BITS(DATA_BITS)) memory (
    .clk_i   (clk),
    .we_i    (mem_we & ~reset),
    .addr_i  (mem_addr),
    .wdata_i (op_d),
    .rdata_o (mem_rdata)
  );

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    ir_hi_d  = ir_hi_q;
    ir_lo_d  = ir_lo_q;
    z_d      = z_q;
    rf_we    = 1'b0;
    rf_wdata = '0;
    mem_we   = 1'b0;
    mem_addr = pc_q;
    alu_res  = '0;
    case (state_q)
      S_FETCH_HI: begin
        ir_hi_d = 8'(mem_rdata);
        pc_d    = pc_q + 8'd1;
        state_d = S_FETCH_LO;
      end
      S_FETCH_LO: begin
        ir_lo_d = 8'(mem_rdata);
        pc_d    = pc_q + 8'd1;
        state_d = S_EXECUTE;
      end
      S_EXECUTE: begin
        state_d  = S_FETCH_HI;
        // Data accesses use the operand byte as address; fetch is idle this cycle.
        mem_addr = ir_lo_q;
        case (opcode)
          4'h1: begin rf_we = 1'b1; rf_wdata = imm_ext;   end
          4'h2: begin rf_we = 1'b1; rf_wdata = op_a;      end
          4'h3: begin rf_we = 1'b1; rf_wdata = mem_rdata; end
          4'h4: mem_we = 1'b1;
          4'h5, 4'h6, 4'h7, 4'h8, 4'h9, 4'hA: begin
            case (opcode)
              4'h5:    alu_res = op_a + op_b;
              4'h6:    alu_res = op_a - op_b;
              4'h7:    alu_res = op_a & op_b;
              4'h8:    alu_res = op_a | op_b;
              4'h9:    alu_res = op_a ^ op_b;
              default: alu_res = op_d + imm_ext;
            endcase
            rf_we    = 1'b1;
            rf_wdata = alu_res;
            z_d      = (alu_res == '0);
          end
          4'hB: pc_d = ir_lo_q;
          4'hC: if (z_q)  pc_d = ir_lo_q;
          4'hD: if (!z_q) pc_d = ir_lo_q;
          default: ;
        endcase
      end
      default: state_d = S_FETCH_HI;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_FETCH_HI;
      pc_q    <= '0;
      ir_hi_q <= '0;
      ir_lo_q <= '0;
      z_q     <= 1'b0;
      for (int i = 0; i < 16; i++) regs_q[i] <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_hi_q <= ir_hi_d;
      ir_lo_q <= ir_lo_d;
      z_q     <= z_d;
      if (rf_we) regs_q[rd] <= rf_wdata;
    end
  end
endmodule

`default_nettype wire

// File: tb/tb_exec_unit.sv
// Bench for exec_unit: instruction-level ISA model compared against the core after every instruction.
`default_nettype none

module tb_exec_unit;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;

  // Instruction-level reference state
  int   m_mem [256];
  int   m_reg [16];
  int   m_pc, m_z, m_ir_hi, m_ir_lo;

  exec_unit #(.DATA_BITS(8)) dut (
    .clk   (clk),
    .reset (reset)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = 0; m_z = 0; m_ir_hi = 0; m_ir_lo = 0;
    for (int i = 0; i < 16; i++) m_reg[i] = 0;
  endtask

  task automatic model_step();
    int hi, lo, op, rd, a, b, res;
    hi = m_mem[m_pc]; m_pc = (m_pc + 1) % 256;
    lo = m_mem[m_pc]; m_pc = (m_pc + 1) % 256;
    m_ir_hi = hi; m_ir_lo = lo;
    op = hi / 16; rd = hi % 16;
    a = m_reg[lo / 16]; b = m_reg[lo % 16];
    res = -1;
    case (op)
      1:  m_reg[rd] = lo;
      2:  m_reg[rd] = a;
      3:  m_reg[rd] = m_mem[lo];
      4:  m_mem[lo] = m_reg[rd];
      5:  res = (a + b) % 256;
      6:  res = (a - b + 256) % 256;
      7:  res = a & b;
      8:  res = a | b;
      9:  res = a ^ b;
      10: res = (m_reg[rd] + lo) % 256;
      11: m_pc = lo;
      12: if (m_z == 1) m_pc = lo;
      13: if (m_z == 0) m_pc = lo;
      default: ;
    endcase
    if (res >= 0) begin
      m_reg[rd] = res;
      m_z = (res == 0) ? 1 : 0;
    end
  endtask

  task automatic load(input int addr, input int val);
    m_mem[addr] = val;
    dut.memory.memory[addr] = val[7:0];
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) load(i, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  task automatic cmp_state(input string tag);
    chk({tag, ".pc"},   32'(dut.pc_q),    32'(m_pc));
    chk({tag, ".z"},    32'(dut.z_q),     32'(m_z));
    chk({tag, ".irhi"}, 32'(dut.ir_hi_q), 32'(m_ir_hi));
    chk({tag, ".irlo"}, 32'(dut.ir_lo_q), 32'(m_ir_lo));
    for (int i = 0; i < 16; i++)
      chk($sformatf("%s.r%0d", tag, i), 32'(dut.regs_q[i]), 32'(m_reg[i]));
  endtask

  task automatic cmp_mem(input string tag);
    for (int i = 0; i < 256; i++)
      chk($sformatf("%s.mem%0d", tag, i), 32'(dut.memory.memory[i]), 32'(m_mem[i]));
  endtask

  // Three rising edges per instruction; sample on the following falling edge.
  task automatic run_instr(input string tag);
    repeat (3) @(posedge clk);
    @(negedge clk);
    model_step();
    cmp_state(tag);
  endtask

  initial begin
    // NOP memory: PC steps by 2 and wraps, registers stay 0
    clear_mem();
    do_reset();
    cmp_state("reset");
    for (int i = 0; i < 128; i++) begin
      run_instr("nop");
      if (i == 126) chk("nop.pc_fe", 32'(dut.pc_q), 32'h0FE);
    end
    chk("nop.pc_wrap", 32'(dut.pc_q), 32'h000);

    // Store/add program with self-modifying operand
    clear_mem();
    load(0, 8'h00); load(1, 8'h00); load(2, 8'h10); load(3, 8'h01);
    load(4, 8'h11); load(5, 8'h10); load(6, 8'h41); load(7, 8'h10);
    load(8, 8'h51); load(9, 8'h10); load(10, 8'h41); load(11, 8'h07);
    load(12, 8'hB0); load(13, 8'h06);
    do_reset();
    for (int i = 0; i < 4; i++) run_instr("prog1");
    chk("prog1.r0", 32'(dut.regs_q[0]), 32'd1);
    chk("prog1.r1", 32'(dut.regs_q[1]), 32'd16);
    chk("prog1.mem16", 32'(dut.memory.memory[16]), 32'd16);
    run_instr("prog1");
    run_instr("prog1");
    chk("smc.r1", 32'(dut.regs_q[1]), 32'd17);
    chk("smc.mem7", 32'(dut.memory.memory[7]), 32'd17);
    chk("smc.z", 32'(dut.z_q), 32'd0);
    run_instr("smc");
    run_instr("smc");
    chk("smc.mem17", 32'(dut.memory.memory[17]), 32'd17);
    for (int i = 0; i < 12; i++) run_instr("smc_loop");
    cmp_mem("smc");

    // Zero flag and conditional jumps
    clear_mem();
    load(0, 8'h12); load(1, 8'hFF); load(2, 8'hA2); load(3, 8'h01);
    load(4, 8'hC0); load(5, 8'h20); load(32, 8'hD0); load(33, 8'h40);
    do_reset();
    run_instr("zf");
    run_instr("zf");
    chk("zf.r2", 32'(dut.regs_q[2]), 32'd0);
    chk("zf.z", 32'(dut.z_q), 32'd1);
    run_instr("jz");
    chk("jz.pc", 32'(dut.pc_q), 32'h20);
    run_instr("jnz");
    chk("jnz.pc", 32'(dut.pc_q), 32'h22);

    // Reset during EXECUTE of a STORE aborts the write
    clear_mem();
    load(0, 8'h11); load(1, 8'h55); load(2, 8'h41); load(3, 8'h80);
    load(128, 8'h33);
    do_reset();
    run_instr("abort");
    repeat (2) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("abort.pc_async", 32'(dut.pc_q), 32'd0);
    chk("abort.r1_async", 32'(dut.regs_q[1]), 32'd0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    chk("abort.mem80", 32'(dut.memory.memory[128]), 32'h33);
    run_instr("restart");
    chk("restart.r1", 32'(dut.regs_q[1]), 32'h55);
    chk("restart.pc", 32'(dut.pc_q), 32'd2);

    // Random programs over the whole memory
    for (int round = 0; round < 3; round++) begin
      for (int i = 0; i < 256; i++) load(i, int'($urandom_range(0, 255)));
      do_reset();
      for (int i = 0; i < 300; i++) run_instr($sformatf("rnd%0d", round));
      cmp_mem($sformatf("rnd%0d", round));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

`default_nettype wire
